// File: rtl/axi4_shared_splitter.sv
// AXI4-shared (combined arw, ID on responses) to split AXI4 (aw/ar, ID-less b/r) bridge.
// Holds one command, steers it by direction, and re-attaches IDs from per-direction FIFOs.

module axi4_shared_splitter_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push at full is still safe.
  assign do_push = push_i & (~full_o | do_pop);
  assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
endmodule

module axi4_shared_splitter #(
  parameter int ADDR_W  = 26,
  parameter int ID_W    = 1,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_arw_valid,
  input  logic              s_arw_write,
  output logic              s_arw_ready,
  input  logic [27:0]       s_arw_addr,
  input  logic [ID_W-1:0]   s_arw_id,
  input  logic [7:0]        s_arw_len,
  input  logic              s_w_valid,
  input  logic              s_w_last,
  input  logic [DATA_W-1:0] s_w_data,
  output logic              s_w_ready,
  output logic              s_b_valid,
  output logic [ID_W-1:0]   s_b_id,
  input  logic              s_b_ready,
  output logic              s_r_valid,
  output logic              s_r_last,
  output logic [DATA_W-1:0] s_r_data,
  output logic [ID_W-1:0]   s_r_id,
  input  logic              s_r_ready,
  output logic              m_awvalid,
  output logic              m_arvalid,
  input  logic              m_awready,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_awlen,
  output logic [7:0]        m_arlen,
  output logic              m_wvalid,
  output logic              m_wlast,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_wready,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic              m_rvalid,
  input  logic              m_rlast,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              m_rready,
  output logic              len_error
);
  localparam int CW = $clog2(MAX_OUT) + 1;

  logic              cmd_full_q, cmd_write_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [7:0]        cmd_len_q;
  logic [CW-1:0]     aw_done_q, aw_done_d;
  logic [7:0]        beat_q, beat_d;
  logic              len_error_q, len_error_d;

  logic aw_hs, ar_hs, cmd_drain, dir_full, arw_hs;
  logic b_hs, r_done, w_open, w_hs, exp_last, w_close;
  logic wid_full, wid_empty, rid_full, rid_empty, wlen_full, wlen_empty;
  logic [7:0] wlen_head;
  logic unused_bits;

  assign aw_hs       = m_awvalid & m_awready;
  assign ar_hs       = m_arvalid & m_arready;
  assign cmd_drain   = aw_hs | ar_hs;
  assign dir_full    = s_arw_write ? wid_full : rid_full;
  assign s_arw_ready = (~cmd_full_q | cmd_drain) & ~dir_full;
  assign arw_hs      = s_arw_valid & s_arw_ready;

  assign m_awvalid = cmd_full_q & cmd_write_q;
  assign m_arvalid = cmd_full_q & ~cmd_write_q;
  assign m_awaddr  = cmd_addr_q;
  assign m_araddr  = cmd_addr_q;
  assign m_awlen   = cmd_len_q;
  assign m_arlen   = cmd_len_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_full_q  <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
    end else if (arw_hs) begin
      cmd_full_q  <= 1'b1;
      cmd_write_q <= s_arw_write;
      cmd_addr_q  <= s_arw_addr[ADDR_W-1:0];
      cmd_len_q   <= s_arw_len;
    end else if (cmd_drain) begin
      cmd_full_q  <= 1'b0;
    end
  end

  // Write data for a burst may only flow once its aw has been handed downstream.
  assign w_open    = (aw_done_q != '0) & ~wlen_empty;
  assign w_hs      = s_w_valid & m_wready & w_open;
  assign m_wvalid  = s_w_valid & w_open;
  assign s_w_ready = m_wready & w_open;
  assign m_wdata   = s_w_data;
  assign m_wlast   = s_w_last;
  assign exp_last  = (beat_q == wlen_head);
  assign w_close   = w_hs & exp_last;

  always_comb begin
    aw_done_d   = aw_done_q + CW'(aw_hs) - CW'(w_close);
    beat_d      = beat_q;
    len_error_d = len_error_q;
    if (w_hs) begin
      beat_d = w_close ? 8'd0 : beat_q + 8'd1;
      if (s_w_last != exp_last) len_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_done_q   <= '0;
      beat_q      <= '0;
      len_error_q <= 1'b0;
    end else begin
      aw_done_q   <= aw_done_d;
      beat_q      <= beat_d;
      len_error_q <= len_error_d;
    end
  end
  assign len_error = len_error_q;

  assign b_hs      = m_bvalid & s_b_ready;
  assign r_done    = m_rvalid & s_r_ready & m_rlast;
  assign s_b_valid = m_bvalid;
  assign m_bready  = s_b_ready;
  assign s_r_valid = m_rvalid;
  assign s_r_last  = m_rlast;
  assign s_r_data  = m_rdata;
  assign m_rready  = s_r_ready;

  axi4_shared_splitter_fifo #(.W(ID_W), .DEPTH(MAX_OUT)) u_wid (
    .clk(clk), .reset(reset), .push_i(arw_hs & s_arw_write), .din_i(s_arw_id),
    .pop_i(b_hs), .head_o(s_b_id), .empty_o(wid_empty), .full_o(wid_full));

  axi4_shared_splitter_fifo #(.W(ID_W), .DEPTH(MAX_OUT)) u_rid (
    .clk(clk), .reset(reset), .push_i(arw_hs & ~s_arw_write), .din_i(s_arw_id),
    .pop_i(r_done), .head_o(s_r_id), .empty_o(rid_empty), .full_o(rid_full));

  axi4_shared_splitter_fifo #(.W(8), .DEPTH(MAX_OUT)) u_wlen (
    .clk(clk), .reset(reset), .push_i(arw_hs & s_arw_write), .din_i(s_arw_len),
    .pop_i(w_close), .head_o(wlen_head), .empty_o(wlen_empty), .full_o(wlen_full));

  assign unused_bits = ^{s_arw_addr[27:ADDR_W], wlen_full, wid_empty, rid_empty};
endmodule
